// File: rtl/i2c_target_regs.sv
// I2C target with a 16 x 8-bit register file: pointer write, burst write and burst read.
// SDA is open-drain (0 or z); SCL is input-only, so there is no clock stretching.
module i2c_target_regs #(
    parameter logic [6:0]  DEVICE_ADDR = 7'h1A,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire        serial_data_line,
    input  logic       serial_clock_line,
    input  logic [3:0] local_addr,
    output logic [7:0] local_data,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [2:0] FILT_MAX = 3'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
    } state_e;

    logic       r_scl_meta, r_scl_sync, r_scl_filt, r_scl_prev;
    logic       r_sda_meta, r_sda_sync, r_sda_filt, r_sda_prev;
    logic [2:0] r_scl_cnt, r_sda_cnt;

    state_e     r_state, w_state_next;
    logic [3:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0] r_shift, w_shift_next;
    logic [3:0] r_ptr, w_ptr_next;
    logic       r_sda_low, w_sda_low_next;
    logic       r_busy, w_busy_next;
    logic       r_rw, w_rw_next;
    logic       w_wr_en;
    logic       r_wr_strobe;
    logic [3:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_regs [16];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_bit_in;
    logic [7:0] w_rd_byte;

    // Synchronizers idle high so a reset never manufactures a START.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_filt <= 1'b1;
            r_scl_prev <= 1'b1;
            r_scl_cnt  <= '0;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_filt <= 1'b1;
            r_sda_prev <= 1'b1;
            r_sda_cnt  <= '0;
        end else begin
            r_scl_meta <= serial_clock_line;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= serial_data_line;
            r_sda_sync <= r_sda_meta;
            if (r_scl_sync == r_scl_filt) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FILT_MAX) begin
                r_scl_filt <= r_scl_sync;
                r_scl_cnt  <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 3'd1;
            end
            if (r_sda_sync == r_sda_filt) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FILT_MAX) begin
                r_sda_filt <= r_sda_sync;
                r_sda_cnt  <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 3'd1;
            end
            r_scl_prev <= r_scl_filt;
            r_sda_prev <= r_sda_filt;
        end
    end

    assign w_scl_rise = r_scl_filt & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_filt & r_scl_prev;
    assign w_start    = ~r_sda_filt & r_sda_prev & r_scl_filt;
    assign w_stop     = r_sda_filt & ~r_sda_prev & r_scl_filt;
    assign w_bit_in   = w_scl_rise && (r_bit_cnt != 4'd8);
    assign w_rd_byte  = r_regs[r_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_ptr       <= '0;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_shift     <= w_shift_next;
            r_ptr       <= w_ptr_next;
            r_sda_low   <= w_sda_low_next;
            r_busy      <= w_busy_next;
            r_rw        <= w_rw_next;
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr      <= r_ptr;
                r_wr_data      <= r_shift;
                r_regs[r_ptr]  <= r_shift;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_ptr_next     = r_ptr;
        w_sda_low_next = r_sda_low;
        w_busy_next    = r_busy;
        w_rw_next      = r_rw;
        w_wr_en        = 1'b0;

        if (w_start) begin
            w_state_next   = StAddr;
            w_bit_cnt_next = '0;
            w_sda_low_next = 1'b0;
            w_busy_next    = 1'b0;
        end else if (w_stop) begin
            w_state_next   = StIdle;
            w_sda_low_next = 1'b0;
            w_busy_next    = 1'b0;
        end else begin
            case (r_state)
                StAddr, StPtr, StWdata: begin
                    if (w_bit_in) begin
                        w_shift_next   = {r_shift[6:0], r_sda_filt};
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_bit_cnt_next = '0;
                        if (r_state == StAddr) begin
                            if (r_shift[7:1] == DEVICE_ADDR) begin
                                w_state_next   = StAddrAck;
                                w_sda_low_next = 1'b1;
                                w_busy_next    = 1'b1;
                                w_rw_next      = r_shift[0];
                            end else begin
                                w_state_next = StIgnore;
                            end
                        end else if (r_state == StPtr) begin
                            w_ptr_next     = r_shift[3:0];
                            w_state_next   = StPtrAck;
                            w_sda_low_next = 1'b1;
                        end else begin
                            w_wr_en        = 1'b1;
                            w_ptr_next     = r_ptr + 4'd1;
                            w_state_next   = StWdataAck;
                            w_sda_low_next = 1'b1;
                        end
                    end
                end
                StAddrAck: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            // ACK release and first read bit share this falling edge.
                            w_shift_next   = w_rd_byte;
                            w_sda_low_next = ~w_rd_byte[7];
                            w_bit_cnt_next = 4'd1;
                            w_state_next   = StRdata;
                        end else begin
                            w_sda_low_next = 1'b0;
                            w_bit_cnt_next = '0;
                            w_state_next   = StPtr;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (w_scl_fall) begin
                        w_sda_low_next = 1'b0;
                        w_bit_cnt_next = '0;
                        w_state_next   = StWdata;
                    end
                end
                StRdata: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            w_shift_next   = w_rd_byte;
                            w_sda_low_next = ~w_rd_byte[7];
                            w_bit_cnt_next = 4'd1;
                        end else if (r_bit_cnt == 4'd8) begin
                            w_sda_low_next = 1'b0;
                            w_state_next   = StRdataAck;
                        end else begin
                            w_shift_next   = {r_shift[6:0], 1'b0};
                            w_sda_low_next = ~r_shift[6];
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end
                StRdataAck: begin
                    if (w_scl_rise) begin
                        if (!r_sda_filt) begin
                            w_ptr_next     = r_ptr + 4'd1;
                            w_bit_cnt_next = '0;
                            w_state_next   = StRdata;
                        end else begin
                            w_state_next = StIgnore;
                            w_busy_next  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign serial_data_line = r_sda_low ? 1'b0 : 1'bz;
    assign local_data       = r_regs[local_addr];
    assign wr_strobe        = r_wr_strobe;
    assign wr_addr          = r_wr_addr;
    assign wr_data          = r_wr_data;
    assign busy             = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master plus a register/write-queue model
// checked against the DUT every cycle, with literal expectations from the test plan.
module tb_i2c_target_regs;

    localparam int Q = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_sda_low;
    wire        sda;
    logic [3:0] local_addr;
    logic [7:0] local_data;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clock = ~clock;

    i2c_target_regs dut (
        .clock             (clock),
        .reset             (reset),
        .serial_data_line  (sda),
        .serial_clock_line (scl),
        .local_addr        (local_addr),
        .local_data        (local_data),
        .wr_strobe         (wr_strobe),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .busy              (busy)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  model_regs [16];
    logic [3:0]  model_ptr;
    logic [7:0]  shadow [16];
    logic [11:0] exp_q [$];
    logic [11:0] obs [$];
    bit          scan_en;
    bit          glitch_en;
    logic [3:0]  lit_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // local_addr sweeps all registers unless a literal peek is in progress.
    initial begin
        local_addr = '0;
        forever begin
            @(posedge clock);
            #1;
            local_addr = scan_en ? local_addr + 4'd1 : lit_addr;
        end
    end

    // Every cycle: strobes must match the expected-write queue, local_data the shadow file.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clock);
            if (reset) begin
                for (int i = 0; i < 16; i++) shadow[i] = '0;
                exp_q.delete();
            end else if (wr_strobe) begin
                obs.push_back({wr_addr, wr_data});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wr_strobe: got addr %0h data %0h, required none",
                             wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[11:8]));
                    check("wr_data", 32'(wr_data), 32'(e[7:0]));
                    shadow[e[11:8]] = e[7:0];
                end
            end else begin
                check("local_data", 32'(local_data), 32'(shadow[local_addr]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clock_bit(input logic b, output logic s);
        cyc(Q);
        m_sda_low = ~b;
        cyc(Q);
        scl = 1'b1;
        if (glitch_en) begin
            cyc(Q / 2);
            scl = 1'b0;
            cyc(1);
            scl = 1'b1;
            cyc(Q / 2 - 1);
        end else begin
            cyc(Q);
        end
        s = sda;
        cyc(Q);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        m_sda_low = 1'b1;
        cyc(Q);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        cyc(Q);
        m_sda_low = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        m_sda_low = 1'b0;
        cyc(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(~master_ack, s);
    endtask

    // Bytes come MSB-first out of 'bytes'; the first one after the address is the pointer.
    task automatic write_txn(input logic [7:0] addr_b, input logic [31:0] bytes, input int n,
                             input bit do_stop);
        logic       a;
        logic       match;
        logic [7:0] b;
        match = (addr_b[7:1] == 7'h1A) && !addr_b[0];
        start_cond();
        send_byte(addr_b, a);
        check("addr_ack", 32'(a), 32'(match));
        check("busy_after_addr", 32'(busy), 32'(match));
        for (int i = 0; i < n; i++) begin
            b = bytes[31 - 8 * i -: 8];
            if (match && i > 0) begin
                exp_q.push_back({model_ptr, b});
                model_regs[model_ptr] = b;
                model_ptr = model_ptr + 4'd1;
            end
            send_byte(b, a);
            check("data_ack", 32'(a), 32'(match));
            if (match && i == 0) model_ptr = b[3:0];
        end
        if (do_stop) begin
            stop_cond();
            check("busy_after_stop", 32'(busy), 32'd0);
        end
    endtask

    task automatic read_txn(input int n, output logic [15:0] got);
        logic       a;
        logic [7:0] d;
        logic [7:0] e;
        got = '0;
        start_cond();
        send_byte(8'h35, a);
        check("rd_addr_ack", 32'(a), 32'd1);
        for (int i = 0; i < n; i++) begin
            e = model_regs[model_ptr];
            recv_byte(i < n - 1, d);
            check("rd_byte", 32'(d), 32'(e));
            got = {got[7:0], d};
            if (i < n - 1) model_ptr = model_ptr + 4'd1;
        end
        check("busy_after_nack", 32'(busy), 32'd0);
        cyc(8);
        check("sda_released_after_nack", 32'(sda), 32'd1);
        stop_cond();
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] req, input string name);
        scan_en  = 1'b0;
        lit_addr = a;
        cyc(2);
        check(name, 32'(local_data), 32'(req));
        scan_en = 1'b1;
    endtask

    initial begin
        logic [15:0] got;
        logic        a;
        logic        s;
        reset     = 1'b1;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        scan_en   = 1'b1;
        glitch_en = 1'b0;
        lit_addr  = '0;
        model_ptr = '0;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        cyc(5);
        reset = 1'b0;
        cyc(2);
        check("reset_sda", 32'(sda), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
        check("reset_wr_addr", 32'(wr_addr), 32'd0);
        check("reset_wr_data", 32'(wr_data), 32'd0);

        // Burst write: pointer 5, then A5, 3C.
        write_txn(8'h34, 32'h05A53C00, 3, 1'b1);
        check("burst_strobe_count", 32'(obs.size()), 32'd2);
        check("burst_strobe0", 32'(obs[0]), 32'h5A5);
        check("burst_strobe1", 32'(obs[1]), 32'h63C);
        peek(4'd5, 8'hA5, "local_data_r5");
        peek(4'd6, 8'h3C, "local_data_r6");

        // Pointer write, repeated START, read two bytes.
        write_txn(8'h34, 32'h05000000, 1, 1'b0);
        read_txn(2, got);
        check("read_bytes", 32'(got), 32'hA53C);

        // Foreign address is never acknowledged.
        write_txn(8'h36, 32'h00000000, 1, 1'b1);
        check("mismatch_strobe_count", 32'(obs.size()), 32'd2);

        // Pointer wrap 15 -> 0.
        write_txn(8'h34, 32'h0F112200, 3, 1'b1);
        check("wrap_strobe0", 32'(obs[2]), 32'hF11);
        check("wrap_strobe1", 32'(obs[3]), 32'h022);
        peek(4'd15, 8'h11, "local_data_r15");
        peek(4'd0, 8'h22, "local_data_r0");

        // One-cycle SCL low pulses inside every high phase.
        glitch_en = 1'b1;
        write_txn(8'h34, 32'h09770000, 2, 1'b1);
        glitch_en = 1'b0;
        check("glitch_strobe", 32'(obs[4]), 32'h977);

        // START after four address bits restarts the address phase.
        start_cond();
        clock_bit(1'b0, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        write_txn(8'h34, 32'h025A0000, 2, 1'b1);
        check("abort_strobe", 32'(obs[5]), 32'h25A);

        // Reset while the target drives the first (zero) bit of reg6 = 3C.
        write_txn(8'h34, 32'h06000000, 1, 1'b0);
        start_cond();
        send_byte(8'h35, a);
        check("rst_rd_addr_ack", 32'(a), 32'd1);
        cyc(Q);
        check("sda_driven_low_before_reset", 32'(sda), 32'd0);
        reset = 1'b1;
        cyc(1);
        check("sda_released_on_reset", 32'(sda), 32'd1);
        model_ptr = '0;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        cyc(3);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            clock_bit(1'b1, s);
            check("no_response_after_reset", 32'(s), 32'd1);
        end
        check("busy_after_reset", 32'(busy), 32'd0);
        peek(4'd6, 8'h00, "local_data_r6_after_reset");
        peek(4'd5, 8'h00, "local_data_r5_after_reset");
        stop_cond();

        // A fresh START works again.
        write_txn(8'h34, 32'h03990000, 2, 1'b1);
        check("final_strobe", 32'(obs[6]), 32'h399);
        check("total_strobes", 32'(obs.size()), 32'd7);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
